nonce_result_queue: RTL and testbench
=====================================

NONCE_RESULT_QUEUE -- requirements
Module: nonce_result_queue

Interface
REQ-001 Parameter NUM_COPIES, default 4: number of hashing lanes reporting hits (1..8).
REQ-002 Parameter DEPTH, default 8: result FIFO entries; power of two, 2..64.
REQ-003 Parameter FRAME_TAIL, default 64'hdead432987beefaa: constant placed in frame bits [255:192].
REQ-004 clk  input  1: single clock; all state on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 hit_valid  input  NUM_COPIES: one-cycle strobe per lane; lane i found a qualifying nonce.
REQ-007 hit_nonce  input  32*NUM_COPIES: lane i nonce at bits [32*i+31:32*i]; sampled only when hit_valid[i]=1.
REQ-008 flush  input  1: synchronous discard of all pending and queued results (new work loaded).
REQ-009 tx_ready  input  1: UART frame transmitter idle and able to accept a frame.
REQ-010 tx_req  output  1: one-cycle request to transmit tx_data.
REQ-011 tx_data  output  256: frame, held stable from tx_req until the next tx_req.
REQ-012 fifo_count  output  log2(DEPTH)+1: current FIFO occupancy.
REQ-013 drop_count  output  16: saturating count of hits lost to lane overrun.

Function
REQ-014 Each lane SHALL have a pending bit plus 32-bit nonce register; hit_valid[i] with pending[i]=0 sets pending[i] and captures the nonce.
REQ-015 hit_valid[i] while pending[i]=1 and not being cleared that cycle SHALL discard the new hit and increment drop_count (saturate at 16'hffff).
REQ-016 Each cycle, the lowest-index pending lane SHALL be pushed into the FIFO if not full and pending cleared; at most one push per cycle.
REQ-017 Lane pushed in cycle N SHALL accept a new hit in cycle N without drop (clear and set same cycle -> pending stays 1 with new nonce).
REQ-018 FIFO full SHALL stall pushes; lanes stay pending, no data lost until a lane overruns per REQ-015.
REQ-019 FIFO entry SHALL store nonce (32 bits) and lane index (3 bits).
REQ-020 Transmit FSM states: IDLE, HOLD.
REQ-021 IDLE: if FIFO non-empty and tx_ready=1 -> assert tx_req one cycle, load tx_data from head, pop, go HOLD.
REQ-022 HOLD: remain until tx_ready=0 observed, then return to IDLE; a frame never issues while in HOLD.
REQ-023 tx_data layout: [7:0]=8'haa, [39:8]=nonce, [47:40]=8'haa, [55:48]=lane index zero-extended, [63:56]=seq, [191:64]=0, [255:192]=FRAME_TAIL.
REQ-024 seq SHALL be an 8-bit counter incremented per issued frame, wrapping 255->0; not affected by flush.
REQ-025 Push and pop in the same cycle SHALL leave fifo_count unchanged; pointers wrap modulo DEPTH.
REQ-026 flush SHALL clear all pending bits and empty the FIFO next edge; hits in the flush cycle are discarded, not counted as drops; FSM state, tx_data, seq, drop_count unaffected.
REQ-027 Latency: hit on idle lane with empty FIFO and tx_ready=1 SHALL produce tx_req 2 cycles later (capture, push, issue).

Reset
REQ-028 rst_n=0 SHALL asynchronously clear pending bits, FIFO pointers, fifo_count=0, drop_count=0, seq=0, tx_req=0, tx_data=0, FSM=IDLE.
REQ-029 Reset mid-HOLD or with queued results SHALL discard them; no tx_req in the first cycle after release.

Configuration
REQ-030 Macro RESULT_DEDUP_EN defined: a lane result whose nonce equals the last nonce pushed to the FIFO (since reset/flush) SHALL be dropped at push time, pending cleared, drop_count unchanged.
REQ-031 RESULT_DEDUP_EN undefined: every pending result is pushed; no last-nonce register present.

Verification
REQ-032 Single hit lane 2 nonce 32'hb2957c02, tx_ready=1 -> tx_req 2 cycles later, tx_data[39:8]=32'hb2957c02, [55:48]=8'h02, [63:56]=8'h00.
REQ-033 Simultaneous hits lanes 0,1,3 (nonces 10,11,13), tx_ready toggled per frame -> three frames in lane order 0,1,3, seq 0,1,2, drop_count=0.
REQ-034 tx_ready=0, hits fill FIFO (8 entries) plus lane 0 pending, then second lane 0 hit -> fifo_count=8, drop_count=1; release tx_ready -> 9 frames total.
REQ-035 Queue 3 results then pulse flush -> fifo_count=0 next cycle, no further tx_req, seq continues from prior value.
REQ-036 RESULT_DEDUP_EN: lanes 0 and 1 hit same nonce 32'h00001234 -> one frame; undefined -> two frames.
REQ-037 Assert rst_n=0 asynchronously while in HOLD with 4 queued -> all outputs zero immediately, no tx_req after release.

Source files
------------

// File: rtl/nonce_result_queue_if.sv
// rtl/nonce_result_queue_if.sv - hit input and frame output bundle for nonce_result_queue
interface nonce_result_queue_if #(
    parameter int NUM_COPIES = 4
);
    logic [NUM_COPIES-1:0]    hit_valid;
    logic [32*NUM_COPIES-1:0] hit_nonce;
    logic                     flush;
    logic                     tx_ready;
    logic                     tx_req;
    logic [255:0]             tx_data;

    modport master (
        output hit_valid, hit_nonce, flush, tx_ready,
        input  tx_req, tx_data
    );

    modport slave (
        input  hit_valid, hit_nonce, flush, tx_ready,
        output tx_req, tx_data
    );
endinterface

// File: rtl/nonce_result_queue.sv
// rtl/nonce_result_queue.sv - per-lane hit capture, result FIFO and UART frame issue
// Optional macro RESULT_DEDUP_EN: drop results repeating the last nonce pushed.
module nonce_result_queue #(
    parameter int          NUM_COPIES = 4,
    parameter int          DEPTH      = 8,
    parameter logic [63:0] FRAME_TAIL = 64'hdead432987beefaa
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nonce_result_queue_if.slave    bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            drop_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, HOLD} tx_state_t;

    logic [NUM_COPIES-1:0] pending;
    logic [31:0]           lane_nonce [NUM_COPIES];
    logic [34:0]           mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [7:0]            seq;
    tx_state_t             state;
    tx_state_t             state_nxt;

    logic                  any_pending;
    logic [2:0]            sel_lane;
    logic [31:0]           sel_nonce;
    logic                  fifo_full;
    logic                  push_fire;
    logic                  push_write;
    logic                  dup;
    logic                  issue;
    logic [NUM_COPIES-1:0] clr_mask;
    logic [NUM_COPIES-1:0] drop_mask;
    logic [3:0]            drop_sum;
    logic [16:0]           drop_next;
    logic [2:0]            head_lane;
    logic [31:0]           head_nonce;

    // Scan high to low so the lowest-index pending lane wins.
    always_comb begin
        any_pending = 1'b0;
        sel_lane    = '0;
        sel_nonce   = '0;
        for (int i = NUM_COPIES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                any_pending = 1'b1;
                sel_lane    = 3'(i);
                sel_nonce   = lane_nonce[i];
            end
        end
    end

    assign fifo_full  = (fifo_count == (AW + 1)'(DEPTH));
    assign push_fire  = any_pending && !fifo_full && !bus.flush;
    assign push_write = push_fire && !dup;

`ifdef RESULT_DEDUP_EN
    logic        last_valid;
    logic [31:0] last_nonce;

    assign dup = last_valid && (last_nonce == sel_nonce);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_valid <= 1'b0;
            last_nonce <= '0;
        end else if (bus.flush) begin
            last_valid <= 1'b0;
        end else if (push_write) begin
            last_valid <= 1'b1;
            last_nonce <= sel_nonce;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // A lane being emptied this cycle may take a new hit without counting a drop.
    always_comb begin
        clr_mask  = '0;
        drop_mask = '0;
        drop_sum  = '0;
        for (int i = 0; i < NUM_COPIES; i++) begin
            clr_mask[i]  = push_fire && (sel_lane == 3'(i));
            drop_mask[i] = bus.hit_valid[i] && pending[i] && !clr_mask[i] && !bus.flush;
            drop_sum     = drop_sum + 4'(drop_mask[i]);
        end
        drop_next = {1'b0, drop_count} + 17'(drop_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_COPIES; i++) lane_nonce[i] <= '0;
        end else if (bus.flush) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_COPIES; i++) begin
                if (bus.hit_valid[i] && (!pending[i] || clr_mask[i])) begin
                    pending[i]    <= 1'b1;
                    lane_nonce[i] <= bus.hit_nonce[32*i +: 32];
                end else if (clr_mask[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop_next[16]) begin
            drop_count <= 16'hffff;
        end else begin
            drop_count <= drop_next[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push_write) mem[wr_ptr] <= {sel_lane, sel_nonce};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (bus.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_write) wr_ptr <= wr_ptr + 1'b1;
            if (issue)      rd_ptr <= rd_ptr + 1'b1;
            case ({push_write, issue})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Issue is held off during flush so the discarded head never reaches tx_data.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if ((fifo_count != '0) && bus.tx_ready && !bus.flush) begin
                    issue     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!bus.tx_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign head_lane  = mem[rd_ptr][34:32];
    assign head_nonce = mem[rd_ptr][31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tx_req  <= 1'b0;
            bus.tx_data <= '0;
            seq         <= '0;
        end else begin
            bus.tx_req <= issue;
            if (issue) begin
                bus.tx_data <= {FRAME_TAIL, 128'd0, seq, 5'd0, head_lane,
                                8'haa, head_nonce, 8'haa};
                seq         <= seq + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nonce_result_queue.sv
// tb/tb_nonce_result_queue.sv - randomized scoreboard bench for nonce_result_queue
module tb_nonce_result_queue;
    localparam int          NC    = 4;
    localparam int          DEPTH = 8;
    localparam logic [63:0] TAIL  = 64'hdead432987beefaa;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  fifo_count;
    logic [15:0] drop_count;

    nonce_result_queue_if #(.NUM_COPIES(NC)) bus ();

    nonce_result_queue #(.NUM_COPIES(NC), .DEPTH(DEPTH), .FRAME_TAIL(TAIL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .fifo_count (fifo_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  lane;
        logic [31:0] nonce;
    } entry_t;

    entry_t       m_q[$];
    logic [255:0] exp_q[$];
    bit           m_pend[NC];
    logic [31:0]  m_nonce[NC];
    int           m_drop;
    int           m_seq;
    bit           m_hold;
    bit           m_last_v;
    logic [31:0]  m_last;
    int           total = 0;
    int           bad = 0;
    int           frames = 0;
    bit           auto_tx = 1'b0;
    int           tx_busy = 0;
    logic [255:0] last_frame = '0;

    function automatic logic [255:0] frame(input entry_t e, input int s);
        logic [255:0] f = '0;
        f[7:0]     = 8'haa;
        f[39:8]    = e.nonce;
        f[47:40]   = 8'haa;
        f[55:48]   = {5'd0, e.lane};
        f[63:56]   = s[7:0];
        f[255:192] = TAIL;
        return f;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        for (int i = 0; i < NC; i++) begin
            m_pend[i]  = 1'b0;
            m_nonce[i] = '0;
        end
        m_drop = 0; m_seq = 0; m_hold = 1'b0; m_last_v = 1'b0; m_last = '0;
    endtask

    function automatic bit model_busy();
        bit b = (m_q.size() > 0) || (exp_q.size() > 0);
        for (int i = 0; i < NC; i++) if (m_pend[i]) b = 1'b1;
        return b;
    endfunction

    // Reference: what the next clock edge does to lanes, queue, frames and drops.
    task automatic model_step(input logic [NC-1:0] hv, input logic [32*NC-1:0] hn,
                              input bit fl, input bit trdy);
        int     pre;
        bit     pop;
        int     sel;
        entry_t e;
        pre = m_q.size();
        pop = !m_hold && (pre > 0) && trdy && !fl;
        if (pop) begin
            exp_q.push_back(frame(m_q[0], m_seq));
            void'(m_q.pop_front());
            m_seq  = (m_seq + 1) % 256;
            m_hold = 1'b1;
        end else if (!trdy) begin
            m_hold = 1'b0;
        end
        if (fl) begin
            for (int i = 0; i < NC; i++) m_pend[i] = 1'b0;
            m_q.delete();
            m_last_v = 1'b0;
            return;
        end
        sel = -1;
        for (int i = NC - 1; i >= 0; i--) if (m_pend[i]) sel = i;
        if (sel >= 0 && pre < DEPTH) begin
            e.lane  = 3'(sel);
            e.nonce = m_nonce[sel];
            m_pend[sel] = 1'b0;
`ifdef RESULT_DEDUP_EN
            if (!(m_last_v && m_last == e.nonce)) begin
                m_q.push_back(e);
                m_last_v = 1'b1;
                m_last   = e.nonce;
            end
`else
            m_q.push_back(e);
`endif
        end
        for (int i = 0; i < NC; i++) begin
            if (hv[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i]  = 1'b1;
                    m_nonce[i] = hn[32*i +: 32];
                end else if (m_drop < 16'hffff) begin
                    m_drop++;
                end
            end
        end
    endtask

    task automatic cycle(input logic [NC-1:0] hv, input logic [32*NC-1:0] hn, input bit fl);
        if (auto_tx) begin
            if (bus.tx_req) begin
                tx_busy      = $urandom_range(1, 3);
                bus.tx_ready = 1'b0;
            end else if (tx_busy > 0) begin
                tx_busy--;
                bus.tx_ready = (tx_busy == 0);
            end else begin
                bus.tx_ready = 1'b1;
            end
        end
        bus.hit_valid = hv;
        bus.hit_nonce = hn;
        bus.flush     = fl;
        model_step(hv, hn, fl, bus.tx_ready);
        @(negedge clk);
        check("fifo_count", 256'(fifo_count), 256'(m_q.size()));
        check("drop_count", 256'(drop_count), 256'(m_drop));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle('0, '0, 1'b0);
    endtask

    task automatic drain();
        int budget = 300;
        while (model_busy() && budget > 0) begin
            cycle('0, '0, 1'b0);
            budget--;
        end
        idle(2);
        check("drain_timeout", 256'(model_busy()), 256'(0));
    endtask

    task automatic set_manual(input bit rdy);
        auto_tx      = 1'b0;
        tx_busy      = 0;
        bus.tx_ready = rdy;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_frame = '0;
        end else if (bus.tx_req) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_tx_req actual=1 required=0");
            end else begin
                last_frame = exp_q.pop_front();
                check("tx_data", bus.tx_data, last_frame);
                frames++;
            end
        end else begin
            check("tx_data_hold", bus.tx_data, last_frame);
        end
    end

    initial begin
        logic [NC-1:0]    hv;
        logic [32*NC-1:0] hn;
        int               f0;
        int               d0;

        bus.hit_valid = '0; bus.hit_nonce = '0; bus.flush = 1'b0; bus.tx_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx_req", 256'(bus.tx_req), 256'(0));
        check("reset_tx_data", bus.tx_data, 256'(0));
        check("reset_fifo_count", 256'(fifo_count), 256'(0));
        check("reset_drop_count", 256'(drop_count), 256'(0));

        // Single lane-2 hit: two edges from capture to tx_req.
        set_manual(1'b1);
        hn = '0; hn[95:64] = 32'hb2957c02;
        cycle(4'b0100, hn, 1'b0);
        idle(2);
        check("latency_tx_req", 256'(bus.tx_req), 256'(1));
        check("latency_nonce", 256'(bus.tx_data[39:8]), 256'(32'hb2957c02));
        check("latency_lane", 256'(bus.tx_data[55:48]), 256'(8'h02));
        check("latency_seq", 256'(bus.tx_data[63:56]), 256'(8'h00));
        bus.tx_ready = 1'b0;
        idle(1);

        // Three simultaneous hits drain in lane order.
        auto_tx = 1'b1;
        f0 = frames;
        hn = '0; hn[31:0] = 32'd10; hn[63:32] = 32'd11; hn[127:96] = 32'd13;
        cycle(4'b1011, hn, 1'b0);
        drain();
        check("multi_frames", 256'(frames - f0), 256'(3));

        // Fill the FIFO with tx held off, then overrun lane 0.
        set_manual(1'b0);
        d0 = m_drop;
        for (int k = 0; k < 10; k++) begin
            hn = '0; hn[31:0] = 32'h100 + 32'(k);
            cycle(4'b0001, hn, 1'b0);
        end
        check("full_fifo_count", 256'(fifo_count), 256'(8));
        check("full_drop_delta", 256'(drop_count - 16'(d0)), 256'(1));
        f0 = frames;
        auto_tx = 1'b1;
        drain();
        check("full_frames", 256'(frames - f0), 256'(9));

        // Flush discards three queued results.
        set_manual(1'b0);
        hn = '0; hn[31:0] = 32'h200; hn[63:32] = 32'h201; hn[95:64] = 32'h202;
        cycle(4'b0111, hn, 1'b0);
        idle(4);
        cycle('0, '0, 1'b1);
        check("flush_fifo_count", 256'(fifo_count), 256'(0));
        f0 = frames;
        auto_tx = 1'b1;
        idle(10);
        check("flush_no_frames", 256'(frames - f0), 256'(0));

        // Two lanes reporting the same nonce.
        f0 = frames;
        hn = '0; hn[31:0] = 32'h00001234; hn[63:32] = 32'h00001234;
        cycle(4'b0011, hn, 1'b0);
        drain();
`ifdef RESULT_DEDUP_EN
        check("dup_frames", 256'(frames - f0), 256'(1));
`else
        check("dup_frames", 256'(frames - f0), 256'(2));
`endif

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 600; k++) begin
            hv = '0; hn = '0;
            for (int i = 0; i < NC; i++) begin
                hv[i] = ($urandom_range(0, 4) == 0);
                hn[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'h55 : $urandom;
            end
            cycle(hv, hn, ($urandom_range(0, 60) == 0));
        end
        drain();

        // Asynchronous reset while holding a frame with four results queued.
        set_manual(1'b0);
        hn = '0;
        for (int i = 0; i < NC; i++) hn[32*i +: 32] = 32'h300 + 32'(i);
        cycle(4'b1111, hn, 1'b0);
        hn = '0; hn[31:0] = 32'h3ff;
        cycle(4'b0001, hn, 1'b0);
        idle(5);
        bus.tx_ready = 1'b1;
        idle(3);
        check("pre_reset_fifo_count", 256'(fifo_count), 256'(4));
        #2 rst_n = 1'b0;
        #1;
        check("areset_tx_req", 256'(bus.tx_req), 256'(0));
        check("areset_tx_data", bus.tx_data, 256'(0));
        check("areset_fifo_count", 256'(fifo_count), 256'(0));
        check("areset_drop_count", 256'(drop_count), 256'(0));
        model_reset();
        bus.hit_valid = '0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_tx_req", 256'(bus.tx_req), 256'(0));
        f0 = frames;
        idle(6);
        check("post_reset_frames", 256'(frames - f0), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
